// File: rtl/matmul_pkg.sv
// Shared definitions for the NxN matrix multiplier.
//   state_e   : controller states (idle, operand load, compute, result done)
//   acc_width : result element width, 2*DATA_W + clog2(N)
//   elem_lsb  : bit offset of element (row, col) in a row-major packed matrix
package matmul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCompute,
    StDone
  } state_e;

  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned n);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic int unsigned elem_lsb(input int unsigned row, input int unsigned col,
                                           input int unsigned n, input int unsigned elem_w);
    return (row * n + col) * elem_w;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single signed multiply-accumulate step for the matrix multiplier.
//   a_i, b_i      : signed operand elements (DATA_W)
//   first_i       : first inner-product term; seed comes from the C seed, not the accumulator
//   accumulate_i  : seed with c_prev_i (1) or zero (0) on the first term
//   c_prev_i      : current C(i,j) value
//   acc_i         : running partial sum
//   sum_o         : seed + sign-extended full-width product, modulo 2^ACC_W
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 65
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic                     first_i,
  input  logic                     accumulate_i,
  input  logic        [ACC_W-1:0]  c_prev_i,
  input  logic        [ACC_W-1:0]  acc_i,
  output logic        [ACC_W-1:0]  sum_o
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned ExtW  = ACC_W - ProdW;

  logic signed [ProdW-1:0] prod;
  logic        [ACC_W-1:0] prod_ext;
  logic        [ACC_W-1:0] seed;

  assign prod     = a_i * b_i;
  assign prod_ext = {{ExtW{prod[ProdW-1]}}, prod};

  always_comb begin
    seed = acc_i;
    if (first_i) begin
      seed = accumulate_i ? c_prev_i : '0;
    end
  end

  assign sum_o = seed + prod_ext;

endmodule

// File: rtl/matrix_multiplier_nxn.sv
// Sequential NxN signed matrix multiplier, one MAC per cycle.
//   input_Clk / input_Reset : clock, asynchronous active-high reset
//   input_Start             : begin a transaction (honoured only in idle)
//   input_Stable            : operands valid on input_A / input_B (honoured only in load)
//   input_Accumulate        : 0 -> C = A*B, 1 -> C = C_prev + A*B
//   input_A / input_B       : row-major packed operand matrices, DATA_W per element
//   input_C_Ack             : consumer has taken the result
//   output_AB_Ack           : ready to capture operands
//   output_Busy             : not idle
//   output_Stable           : result valid on output_C
//   output_C                : row-major packed result, ACC_W per element
module matrix_multiplier_nxn
  import matmul_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned ACC_W = acc_width(DATA_W, N)
) (
  input  logic                      input_Clk,
  input  logic                      input_Reset,
  input  logic                      input_Start,
  input  logic                      input_Stable,
  input  logic                      input_Accumulate,
  input  logic [N*N*DATA_W-1:0]     input_A,
  input  logic [N*N*DATA_W-1:0]     input_B,
  input  logic                      input_C_Ack,
  output logic                      output_AB_Ack,
  output logic                      output_Busy,
  output logic                      output_Stable,
  output logic [N*N*ACC_W-1:0]      output_C
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_i_q, cnt_i_d;
  logic [CntW-1:0]         cnt_j_q, cnt_j_d;
  logic [CntW-1:0]         cnt_k_q, cnt_k_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [N*N*DATA_W-1:0]   a_q, a_d;
  logic [N*N*DATA_W-1:0]   b_q, b_d;
  logic                    mode_q, mode_d;
  logic [N*N*ACC_W-1:0]    c_q, c_d;
  logic                    ab_ack_q, ab_ack_d;
  logic                    busy_q, busy_d;
  logic                    stable_q, stable_d;

  logic [DATA_W-1:0]       a_elem;
  logic [DATA_W-1:0]       b_elem;
  logic [ACC_W-1:0]        c_elem;
  logic [ACC_W-1:0]        mac_sum;

  // Operand selection: A(i,k), B(k,j) and the C(i,j) seed for accumulate mode.
  assign a_elem = a_q[elem_lsb(32'(cnt_i_q), 32'(cnt_k_q), N, DATA_W) +: DATA_W];
  assign b_elem = b_q[elem_lsb(32'(cnt_k_q), 32'(cnt_j_q), N, DATA_W) +: DATA_W];
  assign c_elem = c_q[elem_lsb(32'(cnt_i_q), 32'(cnt_j_q), N, ACC_W) +: ACC_W];

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a_i          (a_elem),
    .b_i          (b_elem),
    .first_i      (cnt_k_q == '0),
    .accumulate_i (mode_q),
    .c_prev_i     (c_elem),
    .acc_i        (acc_q),
    .sum_o        (mac_sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_i_d = cnt_i_q;
    cnt_j_d = cnt_j_q;
    cnt_k_d = cnt_k_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    c_d     = c_q;

    unique case (state_q)
      StIdle: begin
        if (input_Start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (ab_ack_q && input_Stable) begin
          a_d     = input_A;
          b_d     = input_B;
          mode_d  = input_Accumulate;
          cnt_i_d = '0;
          cnt_j_d = '0;
          cnt_k_d = '0;
          state_d = StCompute;
        end
      end
      StCompute: begin
        acc_d = mac_sum;
        if (cnt_k_q == CntLast) begin
          // Last inner term: the sum is final, commit it to C(i,j) on this edge.
          c_d[elem_lsb(32'(cnt_i_q), 32'(cnt_j_q), N, ACC_W) +: ACC_W] = mac_sum;
          cnt_k_d = '0;
          if (cnt_j_q == CntLast) begin
            cnt_j_d = '0;
            if (cnt_i_q == CntLast) begin
              cnt_i_d = '0;
              state_d = StDone;
            end else begin
              cnt_i_d = cnt_i_q + CntOne;
            end
          end else begin
            cnt_j_d = cnt_j_q + CntOne;
          end
        end else begin
          cnt_k_d = cnt_k_q + CntOne;
        end
      end
      StDone: begin
        if (input_C_Ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered copies of the next state.
    ab_ack_d = (state_d == StLoad);
    busy_d   = (state_d != StIdle);
    stable_d = (state_d == StDone);
  end

  always_ff @(posedge input_Clk or posedge input_Reset) begin
    if (input_Reset) begin
      state_q  <= StIdle;
      cnt_i_q  <= '0;
      cnt_j_q  <= '0;
      cnt_k_q  <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      c_q      <= '0;
      ab_ack_q <= 1'b0;
      busy_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_i_q  <= cnt_i_d;
      cnt_j_q  <= cnt_j_d;
      cnt_k_q  <= cnt_k_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      ab_ack_q <= ab_ack_d;
      busy_q   <= busy_d;
      stable_q <= stable_d;
    end
  end

  assign output_AB_Ack = ab_ack_q;
  assign output_Busy   = busy_q;
  assign output_Stable = stable_q;
  assign output_C      = c_q;

endmodule

// File: doc/matrix_multiplier_nxn.md
MATRIX_MULTIPLIER_NXN -- requirements
Module: matrix_multiplier_nxn

Interface
REQ-001 SHALL have parameter N, default 2, meaning matrix dimension, legal 2..4.
REQ-002 SHALL have parameter DATA_W, default 32, meaning signed two's-complement element width.
REQ-003 SHALL have derived localparam ACC_W = 2*DATA_W + clog2(N), the result element width.
REQ-004 SHALL have port input_Clk  in  1  clock, all state changes on its rising edge.
REQ-005 SHALL have port input_Reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port input_Start  in  1  begin a transaction.
REQ-007 SHALL have port input_Stable  in  1  operands valid on input_A/input_B.
REQ-008 SHALL have port input_Accumulate  in  1  mode: 0 computes C=A*B, 1 computes C=C_prev+A*B.
REQ-009 SHALL have port input_A  in  N*N*DATA_W  matrix A; element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W].
REQ-010 SHALL have port input_B  in  N*N*DATA_W  matrix B, same packing.
REQ-011 SHALL have port input_C_Ack  in  1  consumer has taken the result.
REQ-012 SHALL have port output_AB_Ack  out  1  block is ready to capture operands.
REQ-013 SHALL have port output_Busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port output_Stable  out  1  result valid on output_C.
REQ-015 SHALL have port output_C  out  N*N*ACC_W  matrix C, same packing with ACC_W.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, COMPUTE, DONE; all outputs registered.
REQ-017 IDLE: input_Start=1 -> LOAD next edge; input_Start is ignored in all other states.
REQ-018 LOAD: output_AB_Ack=1; on an edge with output_AB_Ack=1 and input_Stable=1, capture A, B and input_Accumulate into internal registers, clear output_AB_Ack, go to COMPUTE.
REQ-019 input_Stable outside LOAD SHALL be ignored; operands are never re-sampled after capture.
REQ-020 COMPUTE SHALL use one signed multiply-accumulate per cycle, iterating i (row), j (col), k (inner), with k innermost, j middle, and i outer.
REQ-021 At k=0 the accumulator SHALL be seeded with 0 (mode 0) or the current C(i,j) (mode 1), plus A(i,0)*B(0,j).
REQ-022 At k=N-1 the accumulator value SHALL be written to C(i,j) on the same edge.
REQ-023 COMPUTE SHALL last exactly N^3 cycles; the edge completing C(N-1,N-1) SHALL enter DONE and set output_Stable=1.
REQ-024 Latency from the capture edge to output_Stable high SHALL be N^3 cycles, which is 8 for N=2.
REQ-025 Products SHALL be full 2*DATA_W signed; sums SHALL be sign-extended to ACC_W and wrap modulo 2^ACC_W, with no saturation. Mode 0 cannot overflow.
REQ-026 DONE: output_Stable=1 and output_C held; input_C_Ack=1 -> IDLE next edge with output_Stable=0 on that edge.
REQ-027 output_C SHALL hold its last value through IDLE/LOAD/COMPUTE until overwritten element-by-element, so mode 1 uses the previous result.
REQ-028 If input_Start and input_C_Ack are both high in DONE, the block SHALL go to IDLE only; Start must be reasserted.

Reset
REQ-029 input_Reset SHALL force, asynchronously and in any state including mid-COMPUTE: state=IDLE, output_C=0, output_AB_Ack=0, output_Busy=0, output_Stable=0, counters=0, accumulator=0.
REQ-030 After reset, the first transaction in mode 1 SHALL accumulate onto an all-zero C.

Structure
REQ-031 Package matmul_pkg SHALL hold the state enumeration, the ACC_W computation function, and the element index/slice helper.
REQ-032 The datapath SHALL be the single sub-module matmul_mac (signed DATA_W x DATA_W multiply, ACC_W add, seed select); the FSM and counters SHALL stay in the top module.

Verification
REQ-033 N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], mode 0 -> C=[[19,22],[43,50]], output_Stable exactly 8 cycles after capture.
REQ-034 Repeat REQ-033 operands with mode 1 -> C=[[38,44],[86,100]].
REQ-035 N=2, A=[[-1,0],[0,-1]], B=[[3,-4],[5,6]] -> C=[[-3,4],[-5,-6]] with correct ACC_W sign extension.
REQ-036 N=3, all elements of A and B = -2^31 -> every C element = 3*2^62, which fits in 66 bits, and latency is 27 cycles.
REQ-037 Assert input_Reset at COMPUTE cycle 3 -> all outputs 0 at once; then Start/Stable with REQ-033 operands in mode 1 -> [[19,22],[43,50]].
REQ-038 Protocol checks: Stable while not in LOAD is ignored; Start in COMPUTE/DONE is ignored; output_Stable holds until input_C_Ack, including a held-off consumer for 10 cycles.
